// File: rtl/div_unit.sv
// Iterative radix-2 restoring divider for RV64M div/divu/rem/remu and the *W forms.
// Accepts one request in IDLE, produces one quotient bit per cycle in CALC, and
// holds the result in DONE until writeback takes it.
// Ports:
//   clock, reset      clock; synchronous active-high reset
//   flush             kills any in-flight operation (pipeline redirect)
//   inValid/inReady   request handshake; inReady high only in IDLE
//   dividend/divisor  rs1/rs2 operands
//   isSigned/isRem/isWord  operation select
//   rdAddr            destination register, carried through to outRdAddr
//   outValid/outReady result handshake; outData/outRdAddr held while stalled
module div_unit (
    input  logic        clock,
    input  logic        reset,
    input  logic        flush,
    input  logic        inValid,
    output logic        inReady,
    input  logic [63:0] dividend,
    input  logic [63:0] divisor,
    input  logic        isSigned,
    input  logic        isRem,
    input  logic        isWord,
    input  logic [4:0]  rdAddr,
    output logic        outValid,
    input  logic        outReady,
    output logic [4:0]  outRdAddr,
    output logic [63:0] outData
);

    localparam int unsigned XLEN  = 64;
    localparam int unsigned HALF  = 32;
    localparam int unsigned CNT_W = 7;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t             state_q, state_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [XLEN-1:0]    rem_q, rem_d;     // partial remainder
    logic [XLEN-1:0]    quo_q, quo_d;     // dividend shifting out, quotient shifting in
    logic [XLEN-1:0]    dvs_q, dvs_d;     // divisor magnitude
    logic               qneg_q, qneg_d;
    logic               rneg_q, rneg_d;
    logic               isrem_q, isrem_d;
    logic               isword_q, isword_d;
    logic [4:0]         rd_q, rd_d;
    logic [XLEN-1:0]    data_q, data_d;

    function automatic logic [XLEN-1:0] sext32(input logic [HALF-1:0] x);
        return {{HALF{x[HALF-1]}}, x};
    endfunction

    // Operand preparation and special-case detection on the live input pins
    logic [XLEN-1:0] a_p, b_p, a_mag, b_mag, spec_res;
    logic            a_neg, b_neg, div_zero, ovf;

    always_comb begin
        a_p      = isWord ? (isSigned ? sext32(dividend[HALF-1:0]) : {{HALF{1'b0}}, dividend[HALF-1:0]})
                          : dividend;
        b_p      = isWord ? (isSigned ? sext32(divisor[HALF-1:0])  : {{HALF{1'b0}}, divisor[HALF-1:0]})
                          : divisor;
        a_neg    = isSigned & a_p[XLEN-1];
        b_neg    = isSigned & b_p[XLEN-1];
        a_mag    = a_neg ? -a_p : a_p;
        b_mag    = b_neg ? -b_p : b_p;
        div_zero = (b_p == '0);
        ovf      = isSigned && (b_p == '1) &&
                   (a_p == (isWord ? 64'hFFFF_FFFF_8000_0000 : 64'h8000_0000_0000_0000));
        spec_res = '0;
        if (div_zero) begin
            spec_res = isRem ? (isWord ? sext32(dividend[HALF-1:0]) : dividend) : '1;
        end else if (ovf) begin
            spec_res = isRem ? '0 : a_p;
        end
    end

    // One restoring shift-subtract step plus sign correction of the final step
    logic [XLEN:0]   r_shift;
    logic            ge;
    logic [XLEN-1:0] rem_nx, quo_nx, q_mag, q_fix, r_fix, sel, final_res;

    always_comb begin
        r_shift   = {rem_q, quo_q[XLEN-1]};
        ge        = (r_shift >= {1'b0, dvs_q});
        rem_nx    = ge ? XLEN'(r_shift - {1'b0, dvs_q}) : r_shift[XLEN-1:0];
        quo_nx    = {quo_q[XLEN-2:0], ge};
        q_mag     = isword_q ? {{HALF{1'b0}}, quo_nx[HALF-1:0]} : quo_nx;
        q_fix     = qneg_q ? -q_mag : q_mag;
        r_fix     = rneg_q ? -rem_nx : rem_nx;
        sel       = isrem_q ? r_fix : q_fix;
        final_res = isword_q ? sext32(sel[HALF-1:0]) : sel;
    end

    // State and datapath registers
    always_ff @(posedge clock) begin
        if (reset) begin
            state_q  <= IDLE;
            cnt_q    <= '0;
            rem_q    <= '0;
            quo_q    <= '0;
            dvs_q    <= '0;
            qneg_q   <= 1'b0;
            rneg_q   <= 1'b0;
            isrem_q  <= 1'b0;
            isword_q <= 1'b0;
            rd_q     <= '0;
            data_q   <= '0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            rem_q    <= rem_d;
            quo_q    <= quo_d;
            dvs_q    <= dvs_d;
            qneg_q   <= qneg_d;
            rneg_q   <= rneg_d;
            isrem_q  <= isrem_d;
            isword_q <= isword_d;
            rd_q     <= rd_d;
            data_q   <= data_d;
        end
    end

    // Next-state and datapath update
    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        rem_d    = rem_q;
        quo_d    = quo_q;
        dvs_d    = dvs_q;
        qneg_d   = qneg_q;
        rneg_d   = rneg_q;
        isrem_d  = isrem_q;
        isword_d = isword_q;
        rd_d     = rd_q;
        data_d   = data_q;

        unique case (state_q)
            IDLE: begin
                if (inValid && !flush) begin
                    rd_d     = rdAddr;
                    isrem_d  = isRem;
                    isword_d = isWord;
                    qneg_d   = a_neg ^ b_neg;
                    rneg_d   = a_neg;
                    dvs_d    = b_mag;
                    rem_d    = '0;
                    // Word ops park the 32-bit magnitude in the top half so the
                    // same MSB-first shift works for 32 iterations.
                    quo_d    = isWord ? {a_mag[HALF-1:0], {HALF{1'b0}}} : a_mag;
                    cnt_d    = isWord ? CNT_W'(HALF - 1) : CNT_W'(XLEN - 1);
                    if (div_zero || ovf) begin
                        data_d  = spec_res;
                        state_d = DONE;
                    end else begin
                        state_d = CALC;
                    end
                end
            end
            CALC: begin
                rem_d = rem_nx;
                quo_d = quo_nx;
                cnt_d = cnt_q - CNT_W'(1);
                if (cnt_q == '0) begin
                    data_d  = final_res;
                    state_d = DONE;
                end
            end
            DONE: begin
                if (outReady) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase

        if (flush) begin
            state_d = IDLE;
        end
    end

    assign inReady   = (state_q == IDLE);
    assign outValid  = (state_q == DONE);
    assign outData   = data_q;
    assign outRdAddr = rd_q;

endmodule

// File: tb/tb_div_unit.sv
module tb_div_unit;

    logic        clock = 1'b0;
    logic        reset;
    logic        flush;
    logic        inValid;
    logic        inReady;
    logic [63:0] dividend;
    logic [63:0] divisor;
    logic        isSigned;
    logic        isRem;
    logic        isWord;
    logic [4:0]  rdAddr;
    logic        outValid;
    logic        outReady;
    logic [4:0]  outRdAddr;
    logic [63:0] outData;

    int n_assert = 0;
    int n_fail   = 0;

    div_unit dut (
        .clock     (clock),
        .reset     (reset),
        .flush     (flush),
        .inValid   (inValid),
        .inReady   (inReady),
        .dividend  (dividend),
        .divisor   (divisor),
        .isSigned  (isSigned),
        .isRem     (isRem),
        .isWord    (isWord),
        .rdAddr    (rdAddr),
        .outValid  (outValid),
        .outReady  (outReady),
        .outRdAddr (outRdAddr),
        .outData   (outData)
    );

    always #5 clock = ~clock;

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed 0x%h expected 0x%h", tag, obs, exp);
        end
    endtask

    // RISC-V M-extension semantics from plain arithmetic
    function automatic logic [63:0] model(input logic [63:0] a, input logic [63:0] b,
                                          input logic s, input logic r, input logic w);
        logic [31:0] a32, b32, q32, r32;
        int          sa32, sb32;
        longint      sa, sb;
        logic [63:0] q64, r64;
        if (w) begin
            a32 = a[31:0];
            b32 = b[31:0];
            if (b32 == 32'd0) begin
                q32 = '1;
                r32 = a32;
            end else if (s && a32 == 32'h8000_0000 && b32 == 32'hFFFF_FFFF) begin
                q32 = a32;
                r32 = 32'd0;
            end else if (s) begin
                sa32 = a32;
                sb32 = b32;
                q32  = sa32 / sb32;
                r32  = sa32 % sb32;
            end else begin
                q32 = a32 / b32;
                r32 = a32 % b32;
            end
            return r ? {{32{r32[31]}}, r32} : {{32{q32[31]}}, q32};
        end
        if (b == 64'd0) begin
            q64 = '1;
            r64 = a;
        end else if (s && a == 64'h8000_0000_0000_0000 && b == '1) begin
            q64 = a;
            r64 = 64'd0;
        end else if (s) begin
            sa  = a;
            sb  = b;
            q64 = sa / sb;
            r64 = sa % sb;
        end else begin
            q64 = a / b;
            r64 = a % b;
        end
        return r ? r64 : q64;
    endfunction

    function automatic int exp_latency(input logic [63:0] a, input logic [63:0] b,
                                       input logic s, input logic w);
        if (w) begin
            if (b[31:0] == 32'd0) return 1;
            if (s && a[31:0] == 32'h8000_0000 && b[31:0] == 32'hFFFF_FFFF) return 1;
            return 33;
        end
        if (b == 64'd0) return 1;
        if (s && a == 64'h8000_0000_0000_0000 && b == '1) return 1;
        return 65;
    endfunction

    task automatic scramble_inputs();
        dividend = {$urandom, $urandom};
        divisor  = {$urandom, $urandom};
        isSigned = 1'($urandom);
        isRem    = 1'($urandom);
        isWord   = 1'($urandom);
        rdAddr   = 5'($urandom);
    endtask

    // Present a request, let it be accepted, then count cycles to outValid (bounded)
    task automatic start_op(input string tag, input logic [63:0] a, input logic [63:0] b,
                            input logic s, input logic r, input logic w,
                            input logic [4:0] rd, output int lat);
        @(negedge clock);
        dividend = a;
        divisor  = b;
        isSigned = s;
        isRem    = r;
        isWord   = w;
        rdAddr   = rd;
        inValid  = 1'b1;
        chk({tag, " inReady before accept"}, 64'(inReady), 64'd1);
        @(posedge clock);
        lat = 0;
        do begin
            @(negedge clock);
            lat++;
            if (lat == 1) begin
                inValid = 1'b0;
                scramble_inputs();
            end
        end while (!outValid && lat < 100);
    endtask

    task automatic run_op(input string tag, input logic [63:0] a, input logic [63:0] b,
                          input logic s, input logic r, input logic w, input logic [4:0] rd);
        int lat;
        start_op(tag, a, b, s, r, w, rd, lat);
        chk({tag, " latency"}, 64'(lat), 64'(exp_latency(a, b, s, w)));
        chk({tag, " data"}, outData, model(a, b, s, r, w));
        chk({tag, " rd"}, 64'(outRdAddr), 64'(rd));
        @(posedge clock);
        @(negedge clock);
        chk({tag, " outValid after handshake"}, 64'(outValid), 64'd0);
        chk({tag, " inReady after handshake"}, 64'(inReady), 64'd1);
    endtask

    initial begin
        int          lat;
        logic [63:0] held_data;
        logic [4:0]  held_rd;
        logic        seen;
        logic [63:0] a, b;
        int          mode;

        reset    = 1'b1;
        flush    = 1'b0;
        inValid  = 1'b0;
        outReady = 1'b1;
        dividend = '0;
        divisor  = '0;
        isSigned = 1'b0;
        isRem    = 1'b0;
        isWord   = 1'b0;
        rdAddr   = '0;
        repeat (3) @(posedge clock);
        @(negedge clock);
        reset = 1'b0;
        chk("reset inReady", 64'(inReady), 64'd1);
        chk("reset outValid", 64'(outValid), 64'd0);
        chk("reset outData", outData, 64'd0);
        chk("reset outRdAddr", 64'(outRdAddr), 64'd0);

        // Directed cases
        run_op("divu 100/7", 64'd100, 64'd7, 1'b0, 1'b0, 1'b0, 5'd5);
        run_op("remu 100/7", 64'd100, 64'd7, 1'b0, 1'b1, 1'b0, 5'd6);
        run_op("div -7/2", -64'sd7, 64'd2, 1'b1, 1'b0, 1'b0, 5'd7);
        run_op("rem -7/2", -64'sd7, 64'd2, 1'b1, 1'b1, 1'b0, 5'd8);
        run_op("rem 7/-2", 64'd7, -64'sd2, 1'b1, 1'b1, 1'b0, 5'd9);
        run_op("div 5/0", 64'd5, 64'd0, 1'b1, 1'b0, 1'b0, 5'd10);
        run_op("remu 5/0", 64'd5, 64'd0, 1'b0, 1'b1, 1'b0, 5'd11);
        run_op("remw 0x80000000/0", 64'h0000_0000_8000_0000, 64'd0, 1'b1, 1'b1, 1'b1, 5'd12);
        run_op("div ovf", 64'h8000_0000_0000_0000, '1, 1'b1, 1'b0, 1'b0, 5'd13);
        run_op("rem ovf", 64'h8000_0000_0000_0000, '1, 1'b1, 1'b1, 1'b0, 5'd14);
        run_op("divw ovf", 64'h0000_0000_8000_0000, 64'h0000_0000_FFFF_FFFF, 1'b1, 1'b0, 1'b1, 5'd15);
        run_op("divuw garbage", 64'h1234_5678_FFFF_FFFF, 64'hABCD_0000_0000_0001, 1'b0, 1'b0, 1'b1, 5'd16);
        run_op("remuw garbage", 64'h1234_5678_0000_000A, 64'd3, 1'b0, 1'b1, 1'b1, 5'd17);
        run_op("divu rd0", 64'd1000, 64'd10, 1'b0, 1'b0, 1'b0, 5'd0);

        // Backpressure: result held stable while outReady is low
        outReady = 1'b0;
        start_op("stall", 64'd1000, 64'd7, 1'b0, 1'b0, 1'b0, 5'd9, lat);
        chk("stall latency", 64'(lat), 64'd65);
        chk("stall data", outData, 64'd142);
        held_data = outData;
        held_rd   = outRdAddr;
        for (int i = 0; i < 10; i++) begin
            @(negedge clock);
            chk("stall outValid held", 64'(outValid), 64'd1);
            chk("stall outData held", outData, held_data);
            chk("stall outRdAddr held", 64'(outRdAddr), 64'(held_rd));
        end
        outReady = 1'b1;
        @(posedge clock);
        @(negedge clock);
        chk("stall release inReady", 64'(inReady), 64'd1);
        chk("stall release outValid", 64'(outValid), 64'd0);

        // Flush at T+20 of a 64-bit op
        @(negedge clock);
        dividend = 64'd12345;
        divisor  = 64'd17;
        isSigned = 1'b0;
        isRem    = 1'b0;
        isWord   = 1'b0;
        rdAddr   = 5'd3;
        inValid  = 1'b1;
        @(posedge clock);
        for (int i = 1; i <= 20; i++) begin
            @(negedge clock);
            if (i == 1) inValid = 1'b0;
        end
        flush = 1'b1;
        @(posedge clock);
        @(negedge clock);
        flush = 1'b0;
        chk("flush inReady at T+21", 64'(inReady), 64'd1);
        seen = 1'b0;
        for (int i = 0; i < 80; i++) begin
            @(negedge clock);
            seen = seen | outValid;
        end
        chk("flush outValid never rises", 64'(seen), 64'd0);

        // Flush together with a request in IDLE: not accepted
        @(negedge clock);
        dividend = 64'd5;
        divisor  = 64'd0;
        isSigned = 1'b0;
        isRem    = 1'b0;
        isWord   = 1'b0;
        rdAddr   = 5'd21;
        inValid  = 1'b1;
        flush    = 1'b1;
        @(posedge clock);
        @(negedge clock);
        inValid = 1'b0;
        flush   = 1'b0;
        chk("idle flush no accept inReady", 64'(inReady), 64'd1);
        chk("idle flush no accept outValid", 64'(outValid), 64'd0);

        // Reset mid-CALC
        @(negedge clock);
        dividend = 64'd999;
        divisor  = 64'd4;
        rdAddr   = 5'd30;
        inValid  = 1'b1;
        @(posedge clock);
        @(negedge clock);
        inValid = 1'b0;
        repeat (10) @(negedge clock);
        reset = 1'b1;
        @(posedge clock);
        @(negedge clock);
        reset = 1'b0;
        chk("midcalc reset inReady", 64'(inReady), 64'd1);
        chk("midcalc reset outValid", 64'(outValid), 64'd0);
        chk("midcalc reset outData", outData, 64'd0);
        chk("midcalc reset outRdAddr", 64'(outRdAddr), 64'd0);

        // Randomized operations against the reference model
        for (int i = 0; i < 40; i++) begin
            mode = int'($urandom_range(0, 5));
            a    = {$urandom, $urandom};
            b    = {$urandom, $urandom};
            case (mode)
                0: b = 64'($urandom_range(0, 1)) << $urandom_range(0, 40) & 64'h0;
                1: b = 64'($urandom_range(1, 20)) * (($urandom & 1) != 0 ? -64'sd1 : 64'sd1);
                2: begin
                    a = ($urandom & 1) != 0 ? 64'h8000_0000_0000_0000 : 64'h0000_0000_8000_0000;
                    b = '1;
                end
                3: a = 64'($urandom_range(0, 1000));
                default: ;
            endcase
            run_op("random", a, b, 1'($urandom), 1'($urandom), 1'($urandom), 5'($urandom));
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
